// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive line decoder.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP1,
    EOP2,
    DRAIN
  } rx_state_t;

  localparam int SYNC_ZEROS      = 7;
  localparam int EOP_SE0_LEN     = 2;
  localparam int MAX_BITS_DEF    = 88;
  localparam int STUFF_LIMIT_DEF = 6;

endpackage

// File: rtl/rx_unstuff.sv
// Bit-unstuffing tracker: counts consecutive decoded 1s and flags the bit that
// must be a stuffed 0 (drop it) or is an illegal 1 (stuff violation).
module rx_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_bit,
  input  logic i_en,
  input  logic i_clr,
  output logic o_keep,
  output logic o_stuff_err
);

  localparam int             W     = $clog2(STUFF_LIMIT + 1);
  localparam logic [W-1:0]   LIMIT = W'(STUFF_LIMIT);

  logic [W-1:0] r_ones_cnt;
  logic         w_at_limit;

  assign w_at_limit  = (r_ones_cnt == LIMIT);
  assign o_keep      = ~w_at_limit;
  assign o_stuff_err = w_at_limit & i_bit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ones_cnt <= '0;
    end else if (i_clr) begin
      // The final SYNC bit is a 1 and already counts toward the run.
      r_ones_cnt <= W'(1);
    end else if (i_en) begin
      if (w_at_limit || !i_bit) r_ones_cnt <= '0;
      else                      r_ones_cnt <= r_ones_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nrzi_dec.sv
// USB receive line decoder: NRZI recovery, SYNC hunt, unstuffing and EOP
// framing, delivering a registered payload bitstream with framing/error strobes.
module nrzi_dec
  import usb_rx_pkg::*;
#(
  parameter int MAX_BITS    = MAX_BITS_DEF,
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       line_in,
  input  logic       line_se0,
  input  logic       line_valid,
  output logic       bstr_out,
  output logic       bstr_out_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic [6:0] pkt_len,
  output logic       sync_err,
  output logic       stuff_err,
  output logic       len_err,
  output logic       eop_err
);

  localparam logic [2:0] ZERO_LAST = 3'(SYNC_ZEROS);
  localparam logic [6:0] BIT_LAST  = 7'(MAX_BITS);

  rx_state_t  r_state;
  logic       r_prev_line;
  logic       r_prev_se0;
  logic [2:0] r_zero_cnt;
  logic [6:0] r_bit_cnt;
  logic       r_bstr, r_bstr_valid, r_start, r_end;
  logic [6:0] r_len;
  logic       r_sync_err, r_stuff_err, r_len_err, r_eop_err;

  logic w_sample, w_d, w_sync_ok, w_unstuff_en, w_keep, w_stuff_viol;

  assign w_sample     = line_valid & ~line_se0;
  assign w_d          = (line_in == r_prev_line);
  assign w_sync_ok    = w_sample && (r_state == SYNC) && w_d && (r_zero_cnt == ZERO_LAST);
  assign w_unstuff_en = w_sample && (r_state == DATA);

  rx_unstuff #(.STUFF_LIMIT(STUFF_LIMIT)) u_unstuff (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_bit       (w_d),
    .i_en        (w_unstuff_en),
    .i_clr       (w_sync_ok),
    .o_keep      (w_keep),
    .o_stuff_err (w_stuff_viol)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= IDLE;
      r_prev_line  <= 1'b1;
      r_prev_se0   <= 1'b0;
      r_zero_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_bstr       <= 1'b0;
      r_bstr_valid <= 1'b0;
      r_start      <= 1'b0;
      r_end        <= 1'b0;
      r_len        <= '0;
      r_sync_err   <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_len_err    <= 1'b0;
      r_eop_err    <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless re-asserted below.
      r_bstr_valid <= 1'b0;
      r_start      <= 1'b0;
      r_end        <= 1'b0;
      r_sync_err   <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_len_err    <= 1'b0;
      r_eop_err    <= 1'b0;
      if (line_valid) begin
        r_prev_se0 <= line_se0;
        if (!line_se0) r_prev_line <= line_in;
        case (r_state)
          IDLE: begin
            if (!line_se0 && !w_d) begin
              r_state    <= SYNC;
              r_zero_cnt <= 3'd1;
            end
          end
          SYNC: begin
            if (!line_se0 && !w_d && r_zero_cnt != ZERO_LAST) begin
              r_zero_cnt <= r_zero_cnt + 3'd1;
            end else if (w_sync_ok) begin
              r_state   <= DATA;
              r_start   <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_sync_err <= 1'b1;
              r_state    <= IDLE;
            end
          end
          DATA: begin
            if (line_se0) begin
              r_state <= EOP1;
            end else if (w_stuff_viol) begin
              r_stuff_err <= 1'b1;
              r_state     <= DRAIN;
            end else if (!w_keep) begin
              r_state <= DATA;
            end else if (r_bit_cnt == BIT_LAST) begin
              r_len_err <= 1'b1;
              r_state   <= DRAIN;
            end else begin
              r_bstr       <= w_d;
              r_bstr_valid <= 1'b1;
              r_bit_cnt    <= r_bit_cnt + 7'd1;
            end
          end
          EOP1: begin
            if (line_se0) begin
              r_state <= EOP2;
            end else begin
              r_eop_err <= 1'b1;
              r_state   <= DRAIN;
            end
          end
          EOP2: begin
            if (!line_se0 && line_in) begin
              r_end       <= 1'b1;
              r_len       <= r_bit_cnt;
              r_prev_line <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_eop_err <= 1'b1;
              r_state   <= DRAIN;
            end
          end
          DRAIN: begin
            if (!line_se0 && line_in && r_prev_se0) begin
              r_prev_line <= 1'b1;
              r_state     <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bstr_out       = r_bstr;
  assign bstr_out_valid = r_bstr_valid;
  assign pkt_start      = r_start;
  assign pkt_end        = r_end;
  assign pkt_len        = r_len;
  assign sync_err       = r_sync_err;
  assign stuff_err      = r_stuff_err;
  assign len_err        = r_len_err;
  assign eop_err        = r_eop_err;

endmodule

// File: tb/tb_nrzi_dec.sv
// Self-checking bench for nrzi_dec: cycle vectors, directed framing/error
// sequences, and randomized packets against a packet-level encoder model.
module tb_nrzi_dec;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       line_in = 1'b1, line_se0 = 1'b0, line_valid = 1'b0;
  logic       bstr_out, bstr_out_valid, pkt_start, pkt_end;
  logic [6:0] pkt_len;
  logic       sync_err, stuff_err, len_err, eop_err;

  nrzi_dec dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .line_in        (line_in),
    .line_se0       (line_se0),
    .line_valid     (line_valid),
    .bstr_out       (bstr_out),
    .bstr_out_valid (bstr_out_valid),
    .pkt_start      (pkt_start),
    .pkt_end        (pkt_end),
    .pkt_len        (pkt_len),
    .sync_err       (sync_err),
    .stuff_err      (stuff_err),
    .len_err        (len_err),
    .eop_err        (eop_err)
  );

  always #5 clk = ~clk;

  typedef bit bitq_t[$];
  typedef struct {
    logic        li;
    logic        se0;
    logic        v;
    logic [14:0] exp;
  } vec_t;

  int    n_checks = 0, n_fail = 0;
  int    n_start, n_end, n_sync, n_stuff, n_lenerr, n_eop;
  logic [6:0] got_len;
  bit    got_bits[$];
  int    sample_idx = 0, lenerr_idx = -1, last_payload_idx = 0;
  bit    lvl = 1'b1;
  int    ones_run = 0;
  bit    stall_en = 1'b0;
  vec_t  vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [14:0] pack_out();
    return {pkt_start, bstr_out_valid, bstr_out & bstr_out_valid, pkt_end,
            pkt_end ? pkt_len : 7'd0, sync_err, stuff_err, len_err, eop_err};
  endfunction

  function automatic logic [14:0] ex(input bit st, input bit bv, input bit b, input bit en,
                                     input logic [6:0] len, input logic [3:0] err);
    return {st, bv, b, en, len, err};
  endfunction

  task automatic row(input logic li, input logic se0, input logic v, input logic [14:0] exp);
    vec_t r;
    r.li = li; r.se0 = se0; r.v = v; r.exp = exp;
    vecs.push_back(r);
  endtask

  task automatic clr_acc();
    n_start = 0; n_end = 0; n_sync = 0; n_stuff = 0; n_lenerr = 0; n_eop = 0;
    got_len = '0; lenerr_idx = -1;
    got_bits.delete();
  endtask

  // One line sample, then observe the registered response away from the edge.
  task automatic drive(input logic li, input logic se0, input logic v);
    line_in = li; line_se0 = se0; line_valid = v;
    @(posedge clk); #1;
    sample_idx++;
    check("one_strobe", ($countones({pkt_end, sync_err, stuff_err, len_err, eop_err}) <= 1), 1);
    if (pkt_start) n_start++;
    if (bstr_out_valid) got_bits.push_back(bstr_out);
    if (pkt_end) begin n_end++; got_len = pkt_len; end
    if (sync_err) n_sync++;
    if (stuff_err) n_stuff++;
    if (len_err) begin n_lenerr++; lenerr_idx = sample_idx; end
    if (eop_err) n_eop++;
  endtask

  task automatic maybe_stall();
    if (stall_en && $urandom_range(0, 7) == 0)
      repeat ($urandom_range(1, 3)) drive(1'($urandom), 1'($urandom), 1'b0);
  endtask

  // NRZI encoder model: 0 toggles the line, 1 holds it.
  task automatic send_bit(input bit b);
    maybe_stall();
    if (!b) lvl = ~lvl;
    drive(lvl, 1'b0, 1'b1);
  endtask

  task automatic send_se0();
    maybe_stall();
    drive(1'($urandom), 1'b1, 1'b1);
  endtask

  task automatic send_j();
    maybe_stall();
    lvl = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
  endtask

  task automatic send_sync();
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
    ones_run = 1;
  endtask

  // Payload bit with a stuffed 0 inserted after every run of six 1s.
  task automatic send_pbit(input bit b);
    send_bit(b);
    last_payload_idx = sample_idx;
    ones_run = b ? ones_run + 1 : 0;
    if (ones_run == 6) begin
      send_bit(1'b0);
      ones_run = 0;
    end
  endtask

  task automatic send_payload(input bitq_t bits);
    foreach (bits[i]) send_pbit(bits[i]);
  endtask

  task automatic send_eop();
    send_se0();
    send_se0();
    send_j();
  endtask

  function automatic bitq_t rand_bits(input int n);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 3) != 0);
    return q;
  endfunction

  task automatic check_rx(input string name, input bitq_t exp_bits, input int e_start,
                          input int e_end, input int e_sync, input int e_stuff,
                          input int e_len, input int e_eop);
    int bad = 0;
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
      if (got_bits[i] != exp_bits[i]) bad++;
    check({name, ".start"}, n_start, e_start);
    check({name, ".nbits"}, got_bits.size(), exp_bits.size());
    check({name, ".bits"}, bad, 0);
    check({name, ".end"}, n_end, e_end);
    if (e_end != 0) check({name, ".len"}, got_len, exp_bits.size());
    check({name, ".errs"}, {8'(n_sync), 8'(n_stuff), 8'(n_lenerr), 8'(n_eop)},
          {8'(e_sync), 8'(e_stuff), 8'(e_len), 8'(e_eop)});
  endtask

  task automatic run_pkt(input string name, input bitq_t bits);
    clr_acc();
    repeat ($urandom_range(0, 3)) send_bit(1'b1);
    send_sync();
    send_payload(bits);
    send_eop();
    check_rx(name, bits, 1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    bit    pl_lv[8] = '{1, 1, 0, 1, 1, 0, 0, 0};
    bit    pl_b[8]  = '{0, 1, 0, 0, 1, 0, 1, 1};
    bitq_t q, q88;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", pack_out(), '0);
    @(negedge clk);
    rst_b = 1'b1;

    // Cycle vectors: ACK packet with a stall, bad SYNC, recovery, 8-zero SYNC
    row(1, 0, 1, '0); row(1, 0, 1, '0); row(0, 1, 1, '0);
    for (int i = 0; i < 7; i++) row(1'(i % 2), 0, 1, '0);
    row(0, 0, 1, ex(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      if (i == 2) row(0, 1, 0, '0);
      row(pl_lv[i], 0, 1, ex(0, 1, pl_b[i], 0, 0, 0));
    end
    row(0, 1, 1, '0); row(0, 1, 1, '0);
    row(1, 0, 1, ex(0, 0, 0, 1, 7'd8, 0));
    row(1, 0, 1, '0);
    for (int i = 0; i < 5; i++) row(1'(i % 2), 0, 1, '0);
    row(0, 0, 1, ex(0, 0, 0, 0, 0, 4'b1000));
    row(0, 0, 1, '0);
    for (int i = 0; i < 7; i++) row(1'(i % 2 == 0), 0, 1, '0);
    row(1, 0, 1, ex(1, 0, 0, 0, 0, 0));
    row(0, 1, 1, '0); row(0, 1, 1, '0);
    row(1, 0, 1, ex(0, 0, 0, 1, 7'd0, 0));
    for (int i = 0; i < 7; i++) row(1'(i % 2), 0, 1, '0);
    row(1, 0, 1, ex(0, 0, 0, 0, 0, 4'b1000));
    row(1, 0, 1, '0);
    foreach (vecs[i]) begin
      drive(vecs[i].li, vecs[i].se0, vecs[i].v);
      check($sformatf("vec%0d", i), pack_out(), vecs[i].exp);
    end
    lvl = 1'b1;

    // Stuffing: 0xFF then 0x00, LSB first
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(i < 8);
    run_pkt("stuff_ff00", q);

    // Stuff violation: seven decoded 1s including the SYNC's last bit
    clr_acc();
    send_sync();
    repeat (7) send_bit(1'b1);
    send_eop();
    q.delete();
    repeat (5) q.push_back(1'b1);
    check_rx("stuff_viol", q, 1, 0, 0, 1, 0, 0);
    run_pkt("after_stuff_viol", rand_bits(12));

    // Length: 89 payload bits, error on the 89th
    clr_acc();
    q = rand_bits(89);
    send_sync();
    send_payload(q);
    check("len_err_at_89", lenerr_idx, last_payload_idx);
    send_eop();
    q88 = q[0:87];
    check_rx("len_89", q88, 1, 0, 0, 0, 1, 0);
    run_pkt("len_88", rand_bits(88));

    // EOP: single SE0 then J, then recovery
    clr_acc();
    q = rand_bits(4);
    send_sync(); send_payload(q);
    send_se0(); send_j();
    send_se0(); send_j();
    check_rx("eop_single", q, 1, 0, 0, 0, 0, 1);

    // EOP: three SE0
    clr_acc();
    q = rand_bits(6);
    send_sync(); send_payload(q);
    send_se0(); send_se0(); send_se0(); send_j();
    check_rx("eop_triple", q, 1, 0, 0, 0, 0, 1);
    run_pkt("after_eop_err", rand_bits(9));

    // Stall of 5 samples mid-DATA
    clr_acc();
    q = rand_bits(20);
    send_sync();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) repeat (5) drive(1'($urandom), 1'($urandom), 1'b0);
      send_pbit(q[i]);
    end
    send_eop();
    check_rx("stall5", q, 1, 1, 0, 0, 0, 0);

    // Asynchronous reset mid-DATA
    clr_acc();
    send_sync();
    send_pbit(1'b1); send_pbit(1'b0); send_pbit(1'b1);
    check("pre_rst_valid", {bstr_out_valid, bstr_out}, 2'b11);
    #2 rst_b = 1'b0;
    #1 check("rst_async_outputs", pack_out(), '0);
    line_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    lvl = 1'b1;
    run_pkt("after_reset", rand_bits(15));

    // Randomized packets with random stalls
    stall_en = 1'b1;
    for (int p = 0; p < 40; p++)
      run_pkt($sformatf("rand%0d", p), rand_bits((p % 10 == 0) ? 88 : $urandom_range(1, 88)));
    stall_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
